// File: rtl/arm_regfile_sb_if.sv
// ---------------------------------------------------------------------------
// arm_regfile_sb_if
// Bundle of all non-clock signals of the ARM register file / load scoreboard.
//   master : decode/writeback side (drives addresses, writes, pending-set)
//   slave  : the register file itself
// Signals:
//   ra1/ra2/ra3, rd1/rd2/rd3     Rn/Rm/Rs read addresses and data
//   we0/wa0/wd0                  ALU write port
//   we1/wa1/wd1                  load writeback port (also clears pending)
//   link_we, pc_plus8            BL link write, current PC+8
//   pend_set, pend_addr          load issued to pend_addr
//   stall1/stall2/stall3         addressed read register has a load pending
//   pend_vec                     scoreboard contents (debug)
// ---------------------------------------------------------------------------
interface arm_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int AW     = 4
);
    logic [AW-1:0]     ra1, ra2, ra3;
    logic [DATA_W-1:0] rd1, rd2, rd3;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DATA_W-1:0] wd1;
    logic              link_we;
    logic [DATA_W-1:0] pc_plus8;
    logic              pend_set;
    logic [AW-1:0]     pend_addr;
    logic              stall1, stall2, stall3;
    logic [NREG-1:0]   pend_vec;

    modport master (
        output ra1, ra2, ra3, we0, wa0, wd0, we1, wa1, wd1,
               link_we, pc_plus8, pend_set, pend_addr,
        input  rd1, rd2, rd3, stall1, stall2, stall3, pend_vec
    );

    modport slave (
        input  ra1, ra2, ra3, we0, wa0, wd0, we1, wa1, wd1,
               link_we, pc_plus8, pend_set, pend_addr,
        output rd1, rd2, rd3, stall1, stall2, stall3, pend_vec
    );
endinterface

// File: rtl/arm_regfile_sb.sv
// ---------------------------------------------------------------------------
// arm_regfile_sb
// ARM register file with three combinational read ports, ALU + load write
// ports, BL link write and a per-register pending-load scoreboard.
// R15 is not stored; reading it returns pc_plus8, writes/pending to it drop.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears registers and scoreboard
//   bus    arm_regfile_sb_if.slave (see interface header)
// Optional feature macro: RF_BYPASS_EN
//   defined   : same-cycle write->read forwarding (we1 > we0 > link_we),
//               and a matching we1 suppresses the read's stall flag.
//   undefined : reads return state from before the current edge.
// NREG must be 16 and AW must be log2(NREG).
// ---------------------------------------------------------------------------

// One read port: array lookup plus optional forwarding from the write ports.
module arm_regfile_rdport #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int AW     = 4
) (
    input  logic                        reset_i,
    input  logic [AW-1:0]               ra_i,
    input  logic [NREG-1:0][DATA_W-1:0] rf_i,     // top entry is pc_plus8
    input  logic [NREG-1:0]             pend_i,   // top bit always 0
    input  logic                        we0_i,
    input  logic [AW-1:0]               wa0_i,
    input  logic [DATA_W-1:0]           wd0_i,
    input  logic                        we1_i,
    input  logic [AW-1:0]               wa1_i,
    input  logic [DATA_W-1:0]           wd1_i,
    input  logic                        link_we_i,
    input  logic [DATA_W-1:0]           link_val_i,
    output logic [DATA_W-1:0]           rd_o,
    output logic                        stall_o
);
    localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] LR_IDX = AW'(NREG - 2);

    always_comb begin
        rd_o    = rf_i[ra_i];
        stall_o = pend_i[ra_i];
`ifdef RF_BYPASS_EN
        // Forwarding is held off during reset so reads show the cleared state.
        if (!reset_i && ra_i != PC_IDX) begin
            if (we1_i && wa1_i == ra_i) begin
                rd_o    = wd1_i;
                stall_o = 1'b0;      // the awaited load value is here now
            end else if (we0_i && wa0_i == ra_i) begin
                rd_o = wd0_i;
            end else if (link_we_i && ra_i == LR_IDX) begin
                rd_o = link_val_i;
            end
        end
`endif
    end

`ifndef RF_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{reset_i, we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i,
                          link_we_i, link_val_i};
`endif
endmodule

module arm_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int AW     = 4
) (
    input logic            clk,
    input logic            reset,
    arm_regfile_sb_if.slave bus
);
    localparam int NRD = 3;          // Rn, Rm, Rs
    localparam int LR  = NREG - 2;   // R14

    // Only R0..R14 have storage.
    logic [NREG-2:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-2:0]             pend_q, pend_d;
    logic [DATA_W-1:0]           link_val;

    assign link_val = bus.pc_plus8 - DATA_W'(4);

    // Writes addressed to 15 never match a stored index, so they drop out.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int r = 0; r < NREG - 1; r++) begin
            if (bus.we1 && bus.wa1 == AW'(r))
                regs_d[r] = bus.wd1;
            else if (bus.we0 && bus.wa0 == AW'(r))
                regs_d[r] = bus.wd0;
            else if (bus.link_we && r == LR)
                regs_d[r] = link_val;

            // Clear first so a same-cycle set for a new load wins.
            if (bus.we1 && bus.wa1 == AW'(r))
                pend_d[r] = 1'b0;
            if (bus.pend_set && bus.pend_addr == AW'(r))
                pend_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Full-width views: R15 slot carries pc_plus8 and is never pending.
    logic [NREG-1:0][DATA_W-1:0] rf_view;
    logic [NREG-1:0]             pend_view;

    assign rf_view   = {bus.pc_plus8, regs_q};
    assign pend_view = {1'b0, pend_q};
    assign bus.pend_vec = pend_view;

    logic [NRD-1:0][AW-1:0]     ra;
    logic [NRD-1:0][DATA_W-1:0] rd;
    logic [NRD-1:0]             stall;

    assign ra = {bus.ra3, bus.ra2, bus.ra1};

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        arm_regfile_rdport #(
            .DATA_W (DATA_W),
            .NREG   (NREG),
            .AW     (AW)
        ) u_rdport (
            .reset_i    (reset),
            .ra_i       (ra[p]),
            .rf_i       (rf_view),
            .pend_i     (pend_view),
            .we0_i      (bus.we0),
            .wa0_i      (bus.wa0),
            .wd0_i      (bus.wd0),
            .we1_i      (bus.we1),
            .wa1_i      (bus.wa1),
            .wd1_i      (bus.wd1),
            .link_we_i  (bus.link_we),
            .link_val_i (link_val),
            .rd_o       (rd[p]),
            .stall_o    (stall[p])
        );
    end

    assign bus.rd1    = rd[0];
    assign bus.rd2    = rd[1];
    assign bus.rd3    = rd[2];
    assign bus.stall1 = stall[0];
    assign bus.stall2 = stall[1];
    assign bus.stall3 = stall[2];
endmodule

// File: tb/tb_arm_regfile_sb.sv
module tb_arm_regfile_sb;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_regfile_sb_if #(.DATA_W(32), .NREG(16), .AW(4)) bus ();

    arm_regfile_sb #(.DATA_W(32), .NREG(16), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference state: plain arrays, updated by last-writer-wins ordering.
    logic [31:0] m_reg [16];
    bit          m_pend[16];
    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [3:0] a);
        if (a == 4'd15) return bus.pc_plus8;
`ifdef RF_BYPASS_EN
        if (!reset) begin
            if (bus.we1 && bus.wa1 == a) return bus.wd1;
            if (bus.we0 && bus.wa0 == a) return bus.wd0;
            if (bus.link_we && a == 4'd14) return bus.pc_plus8 - 32'd4;
        end
`endif
        return m_reg[a];
    endfunction

    function automatic logic [31:0] m_stall(input logic [3:0] a);
        if (a == 4'd15) return 32'd0;
`ifdef RF_BYPASS_EN
        if (!reset && bus.we1 && bus.wa1 == a) return 32'd0;
`endif
        return {31'd0, m_pend[a]};
    endfunction

    function automatic logic [31:0] m_pvec();
        logic [31:0] v = '0;
        for (int i = 0; i < 15; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check_all();
        if (reset) m_clear();
        chk("rd1", bus.rd1, m_rd(bus.ra1));
        chk("rd2", bus.rd2, m_rd(bus.ra2));
        chk("rd3", bus.rd3, m_rd(bus.ra3));
        chk("stall1", {31'd0, bus.stall1}, m_stall(bus.ra1));
        chk("stall2", {31'd0, bus.stall2}, m_stall(bus.ra2));
        chk("stall3", {31'd0, bus.stall3}, m_stall(bus.ra3));
        chk("pend_vec", {16'd0, bus.pend_vec}, m_pvec());
    endtask

    // Apply writes lowest priority first so the highest one is left standing.
    task automatic m_commit();
        if (reset) begin
            m_clear();
            return;
        end
        if (bus.link_we) m_reg[14] = bus.pc_plus8 - 32'd4;
        if (bus.we0 && bus.wa0 != 4'd15) m_reg[bus.wa0] = bus.wd0;
        if (bus.we1 && bus.wa1 != 4'd15) m_reg[bus.wa1] = bus.wd1;
        if (bus.we1) m_pend[bus.wa1] = 1'b0;
        if (bus.pend_set) m_pend[bus.pend_addr] = 1'b1;
        m_pend[15] = 1'b0;
    endtask

    task automatic idle();
        bus.we0 = 0; bus.wa0 = 0; bus.wd0 = 0;
        bus.we1 = 0; bus.wa1 = 0; bus.wd1 = 0;
        bus.link_we = 0; bus.pend_set = 0; bus.pend_addr = 0;
    endtask

    // Called at negedge+1 with inputs set: check, clock, update model.
    task automatic cyc();
        check_all();
        @(posedge clk);
        m_commit();
        @(negedge clk);
    endtask

    initial begin
        m_clear();
        reset = 1'b1;
        idle();
        bus.ra1 = 0; bus.ra2 = 0; bus.ra3 = 0;
        bus.pc_plus8 = 32'h108;
        @(negedge clk);
        #1 cyc();
        reset = 1'b0;
        #1 cyc();

        // Reset mid-operation with R3 = 0x55 and bit 3 pending
        bus.we0 = 1; bus.wa0 = 3; bus.wd0 = 32'h55;
        bus.pend_set = 1; bus.pend_addr = 3;
        #1 cyc();
        idle();
        bus.ra1 = 3;
        #1 chk("pre_reset_r3", bus.rd1, 32'h55);
        cyc();
        reset = 1'b1;
        bus.ra1 = 15; bus.ra2 = 3;
        #1;
        chk("reset_r15", bus.rd1, 32'h108);
        chk("reset_r3", bus.rd2, 32'h0);
        chk("reset_pvec", {16'd0, bus.pend_vec}, 32'h0);
        cyc();
        reset = 1'b0;
        #1 cyc();

        // Dual-write collision and independent writes
        bus.we0 = 1; bus.wa0 = 5; bus.wd0 = 32'hA;
        bus.we1 = 1; bus.wa1 = 5; bus.wd1 = 32'hB;
        #1 cyc();
        bus.wa0 = 2; bus.wd0 = 32'h22;
        bus.wa1 = 7; bus.wd1 = 32'h7777;
        bus.ra1 = 5;
        #1 chk("collision_r5", bus.rd1, 32'hB);
        cyc();
        idle();
        bus.ra1 = 2; bus.ra2 = 7;
        #1;
        chk("both_r2", bus.rd1, 32'h22);
        chk("both_r7", bus.rd2, 32'h7777);
        cyc();

        // BL link, then link vs we0 to R14
        bus.pc_plus8 = 32'h1000;
        bus.link_we = 1;
        #1 cyc();
        bus.we0 = 1; bus.wa0 = 14; bus.wd0 = 32'h77;
        bus.ra1 = 14;
`ifndef RF_BYPASS_EN
        #1 chk("link_r14", bus.rd1, 32'hFFC);
`else
        #1;
`endif
        cyc();
        idle();
        #1 chk("link_vs_we0", bus.rd1, 32'h77);
        cyc();

        // Scoreboard set / clear / set-wins
        bus.pend_set = 1; bus.pend_addr = 4;
        #1 cyc();
        idle();
        bus.ra1 = 4;
        #1 chk("sb_stall", {31'd0, bus.stall1}, 32'd1);
        cyc();
        bus.we1 = 1; bus.wa1 = 4; bus.wd1 = 32'h99;
        #1 cyc();
        idle();
        #1;
        chk("sb_clear_stall", {31'd0, bus.stall1}, 32'd0);
        chk("sb_clear_rd", bus.rd1, 32'h99);
        cyc();
        bus.pend_set = 1; bus.pend_addr = 4;
        bus.we1 = 1; bus.wa1 = 4; bus.wd1 = 32'h98;
        #1 cyc();
        idle();
        #1 chk("sb_set_wins", {31'd0, bus.pend_vec[4]}, 32'd1);
        cyc();

        // Same-cycle load writeback while bit 6 pending
        bus.pend_set = 1; bus.pend_addr = 6;
        #1 cyc();
        idle();
        bus.ra2 = 6;
        bus.we1 = 1; bus.wa1 = 6; bus.wd1 = 32'h42;
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_rd2", bus.rd2, 32'h42);
        chk("byp_stall2", {31'd0, bus.stall2}, 32'd0);
`else
        chk("nobyp_rd2", bus.rd2, 32'h0);
        chk("nobyp_stall2", {31'd0, bus.stall2}, 32'd1);
`endif
        cyc();
        idle();

        // R15 writes and pending are dropped
        bus.we0 = 1; bus.wa0 = 15; bus.wd0 = 32'hDEAD;
        bus.pend_set = 1; bus.pend_addr = 15;
        #1 cyc();
        idle();
        bus.ra1 = 15;
        #1;
        chk("r15_rd", bus.rd1, 32'h1000);
        chk("r15_pend", {31'd0, bus.pend_vec[15]}, 32'd0);
        cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            bus.ra1      = 4'($urandom_range(0, 15));
            bus.ra2      = 4'($urandom_range(0, 15));
            bus.ra3      = 4'($urandom_range(0, 15));
            bus.we0      = 1'($urandom_range(0, 1));
            bus.wa0      = 4'($urandom_range(0, 15));
            bus.wd0      = $urandom;
            bus.we1      = 1'($urandom_range(0, 1));
            bus.wa1      = 4'($urandom_range(0, 15));
            bus.wd1      = $urandom;
            bus.link_we  = ($urandom_range(0, 3) == 0);
            bus.pc_plus8 = ($urandom_range(0, 7) == 0) ? 32'd2 : $urandom;
            bus.pend_set = 1'($urandom_range(0, 1));
            bus.pend_addr = 4'($urandom_range(0, 15));
            #1 cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
